dmem_arbiter: RTL and testbench

//  Two-port arbiter and sequencer in front of the 64-entry data memory.

---
 rtl/dmem_arbiter.sv | 135 +++++++++++++
 tb/tb_dmem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer sharing the data memory's single port; one transaction in flight.
// Build option: define DMEM_ARB_FIXED_PRIO_EN to make port A win every tie (default is round-robin).
module dmem_arbiter #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [1:0]    a_size,
   input  logic [AW-1:0] a_addr,
   input  logic [31:0]   a_wdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [1:0]    b_size,
   input  logic [AW-1:0] b_addr,
   input  logic [31:0]   b_wdata,
   output logic          a_gnt,
   output logic          b_gnt,
   output logic          a_ack,
   output logic          b_ack,
   output logic [31:0]   a_rdata,
   output logic [31:0]   b_rdata,
   output logic          a_err,
   output logic          b_err,
   output logic          mem_MemWrite,
   output logic [AW-1:0] mem_Address,
   output logic [31:0]   mem_WriteData,
   output logic [1:0]    mem_MemRead,
   input  logic [31:0]   mem_ReadData
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t        r_state;
   logic          r_last_b;
   logic          r_sel_b;
   logic          r_we;
   logic          r_bad;

   logic          w_idle;
   logic          w_any;
   logic          w_pick_b;
   logic          w_we;
   logic          w_bad;
   logic [1:0]    w_size;
   logic [AW-1:0] w_addr;
   logic [31:0]   w_wdata;
   logic [31:0]   w_rdata;

   always_comb begin
      w_idle   = (r_state == S_IDLE) && !reset;
      w_any    = a_req || b_req;
      // On a tie B wins only if A was served last (round-robin build).
      w_pick_b = b_req && (!a_req || (!FIXED_PRIO && !r_last_b));
      w_we     = w_pick_b ? b_we    : a_we;
      w_size   = w_pick_b ? b_size  : a_size;
      w_addr   = w_pick_b ? b_addr  : a_addr;
      w_wdata  = w_pick_b ? b_wdata : a_wdata;
      w_bad    = (w_addr >= AW'(DEPTH)) || (w_size == 2'd0);
      w_rdata  = (r_we || r_bad) ? '0 : mem_ReadData;
   end

   assign a_gnt = w_idle && a_req && !w_pick_b;
   assign b_gnt = w_idle && w_pick_b;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_last_b      <= 1'b1;
         r_sel_b       <= 1'b0;
         r_we          <= 1'b0;
         r_bad         <= 1'b0;
         a_ack         <= 1'b0;
         b_ack         <= 1'b0;
         a_err         <= 1'b0;
         b_err         <= 1'b0;
         a_rdata       <= '0;
         b_rdata       <= '0;
         mem_MemWrite  <= 1'b0;
         mem_Address   <= '0;
         mem_WriteData <= '0;
         mem_MemRead   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_sel_b       <= w_pick_b;
                  r_last_b      <= w_pick_b;
                  r_we          <= w_we;
                  r_bad         <= w_bad;
                  // Memory command is registered here so it is stable for the whole ACCESS cycle.
                  mem_Address   <= w_addr;
                  mem_WriteData <= w_bad ? '0 : w_wdata;
                  mem_MemWrite  <= !w_bad && w_we;
                  mem_MemRead   <= (w_bad || w_we) ? 2'd0 : w_size;
                  r_state       <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               mem_MemWrite  <= 1'b0;
               mem_Address   <= '0;
               mem_WriteData <= '0;
               mem_MemRead   <= '0;
               if (r_sel_b) begin
                  b_ack   <= 1'b1;
                  b_err   <= r_bad;
                  b_rdata <= w_rdata;
               end else begin
                  a_ack   <= 1'b1;
                  a_err   <= r_bad;
                  a_rdata <= w_rdata;
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               a_ack   <= 1'b0;
               b_ack   <= 1'b0;
               a_err   <= 1'b0;
               b_err   <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level schedule model plus a 64-word memory device.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   typedef struct packed {
      logic        req;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load_mem = 1'b1;
   logic        a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
   logic [1:0]  a_size = '0, b_size = '0;
   logic [31:0] a_addr = '0, b_addr = '0, a_wdata = '0, b_wdata = '0;
   logic        a_gnt, b_gnt, a_ack, b_ack, a_err, b_err, mem_MemWrite;
   logic [31:0] a_rdata, b_rdata, mem_Address, mem_WriteData, mem_ReadData;
   logic [1:0]  mem_MemRead;

   dmem_arbiter #(.DEPTH(64), .AW(32)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_addr(b_addr), .b_wdata(b_wdata),
      .a_gnt(a_gnt), .b_gnt(b_gnt), .a_ack(a_ack), .b_ack(b_ack),
      .a_rdata(a_rdata), .b_rdata(b_rdata), .a_err(a_err), .b_err(b_err),
      .mem_MemWrite(mem_MemWrite), .mem_Address(mem_Address), .mem_WriteData(mem_WriteData),
      .mem_MemRead(mem_MemRead), .mem_ReadData(mem_ReadData)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 5) return 32'hDEADBEEF;
      if (i == 9) return 32'h0BADF00D;
      return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
   endfunction

   function automatic logic [31:0] size_mask(input logic [31:0] w, input logic [1:0] s);
      case (s)
         2'd1:    return {24'h0, w[7:0]};
         2'd2:    return {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Memory device: combinational read shaped by MemRead, write on the clock edge.
   logic [31:0] dev_mem [64];
   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 64; i++) dev_mem[i] <= init_word(i);
      end else if (mem_MemWrite && mem_Address < 32'd64) begin
         dev_mem[mem_Address[5:0]] <= mem_WriteData;
      end
   end
   always_comb begin
      mem_ReadData = '0;
      if (mem_MemRead != 2'd0 && mem_Address < 32'd64)
         mem_ReadData = size_mask(dev_mem[mem_Address[5:0]], mem_MemRead);
   end

   int n_total = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Model state: staged requester commands, one in-flight transaction, expected memory.
   cmd_t        st [2];
   logic [31:0] mmem [64];
   logic [31:0] hold [2];
   bit          eg [2];
   bit          ea [2];
   bit          ee [2];
   int          cyc = 0;
   int          free_at = 0;
   bit          last_p = 1'b1;
   bit          tv = 1'b0;
   int          tg = 0;
   bit          tp, twe, tbad;
   logic [1:0]  tsz;
   logic [31:0] taddr, twd, trd;

   function automatic cmd_t mk(input logic we, input logic [1:0] sz, input logic [31:0] ad,
                               input logic [31:0] wd);
      cmd_t c;
      c.req = 1'b1; c.we = we; c.size = sz; c.addr = ad; c.wdata = wd;
      return c;
   endfunction

   function automatic cmd_t rand_cmd();
      logic [31:0] ad;
      case ($urandom_range(0, 9))
         0:       ad = 32'd64 + 32'($urandom_range(0, 8));
         1:       ad = 32'h0000_0100 | 32'($urandom_range(0, 63));
         2:       ad = $urandom | 32'h8000_0000;
         default: ad = 32'($urandom_range(0, 63));
      endcase
      return mk(1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3)),
                ad, $urandom);
   endfunction

   task automatic run_cycle();
      bit          pb;
      logic        e_mw;
      logic [1:0]  e_mr;
      logic [31:0] e_addr, e_wd;
      @(posedge clk);
      #1;
      {a_req, a_we, a_size, a_addr, a_wdata} = st[0];
      {b_req, b_we, b_size, b_addr, b_wdata} = st[1];
      eg[0] = 0; eg[1] = 0; ea[0] = 0; ea[1] = 0; ee[0] = 0; ee[1] = 0;
      e_mw = 1'b0; e_mr = 2'd0; e_addr = '0; e_wd = '0;
      if (tv && cyc == tg + 1) begin
         e_addr = taddr;
         if (!tbad) begin
            e_mw = twe;
            e_mr = twe ? 2'd0 : tsz;
            e_wd = twd;
         end
         trd = (twe || tbad) ? 32'h0 : size_mask(mmem[taddr[5:0]], tsz);
      end
      if (tv && cyc == tg + 2) begin
         if (twe && !tbad) mmem[taddr[5:0]] = twd;
         ea[tp] = 1; ee[tp] = tbad; hold[tp] = trd; tv = 0;
      end
      if (cyc >= free_at && (st[0].req || st[1].req)) begin
         if (st[0].req && st[1].req) pb = FIXED ? 1'b0 : (last_p == 1'b0);
         else pb = st[1].req;
         eg[pb] = 1; last_p = pb; tv = 1; tg = cyc; free_at = cyc + 3; tp = pb;
         twe = st[pb].we; tsz = st[pb].size; taddr = st[pb].addr; twd = st[pb].wdata;
         tbad = (st[pb].addr >= 32'd64) || (st[pb].size == 2'd0);
      end
      @(negedge clk);
      chk("a_gnt", 32'(a_gnt), 32'(eg[0]));
      chk("b_gnt", 32'(b_gnt), 32'(eg[1]));
      chk("a_ack", 32'(a_ack), 32'(ea[0]));
      chk("b_ack", 32'(b_ack), 32'(ea[1]));
      chk("a_err", 32'(a_err), 32'(ee[0]));
      chk("b_err", 32'(b_err), 32'(ee[1]));
      chk("a_rdata", a_rdata, hold[0]);
      chk("b_rdata", b_rdata, hold[1]);
      chk("MemWrite", 32'(mem_MemWrite), 32'(e_mw));
      chk("MemRead", 32'(mem_MemRead), 32'(e_mr));
      chk("Address", mem_Address, e_addr);
      chk("WriteData", mem_WriteData, e_wd);
      cyc++;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_gnt"}, 32'({a_gnt, b_gnt}), 32'd0);
      chk({tag, "_ack_err"}, 32'({a_ack, b_ack, a_err, b_err}), 32'd0);
      chk({tag, "_rdata"}, a_rdata | b_rdata, 32'd0);
      chk({tag, "_mem"}, 32'({mem_MemWrite, mem_MemRead}) | mem_Address | mem_WriteData, 32'd0);
   endtask

   // Called at a falling edge: asserts reset mid-cycle, holds it, releases away from clk.
   task automatic reset_mid(input int ncyc);
      #2 reset = 1'b1;
      #1 check_zero("rst_now");
      repeat (ncyc) @(posedge clk);
      #1;
      st[0].req = 1'b0; st[1].req = 1'b0; a_req = 1'b0; b_req = 1'b0;
      @(negedge clk);
      check_zero("rst_hold");
      #2 reset = 1'b0;
      tv = 0; last_p = 1'b1; free_at = 0; hold[0] = '0; hold[1] = '0;
   endtask

   task automatic xact(input int p, input logic we, input logic [1:0] sz, input logic [31:0] ad,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int gcyc, output int acyc, output int wcnt, output logic [1:0] mr);
      bit done = 0;
      st[p] = mk(we, sz, ad, wd);
      rd = '0; er = 0; gcyc = -1; acyc = -1; wcnt = 0; mr = '0;
      for (int n = 0; n < 12 && !done; n++) begin
         run_cycle();
         if ((p == 0) ? a_gnt : b_gnt) gcyc = n;
         if (eg[p]) begin
            st[p].addr = ~ad; st[p].wdata = ~wd; st[p].we = ~we;
         end
         wcnt += int'(mem_MemWrite);
         mr |= mem_MemRead;
         if ((p == 0) ? a_ack : b_ack) begin
            acyc = n; rd = (p == 0) ? a_rdata : b_rdata; er = (p == 0) ? a_err : b_err;
            done = 1; st[p].req = 1'b0;
         end
      end
      chk("ack_seen", 32'(done), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          gc, ac, wc;
      logic [1:0]  mr;
      logic [5:0]  seq;
      for (int i = 0; i < 64; i++) mmem[i] = init_word(i);
      hold[0] = '0; hold[1] = '0;
      st[0] = '0; st[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      #2 reset = 1'b0; load_mem = 1'b0;

      xact(0, 1'b0, 2'd3, 32'd5, 32'h0, rd, er, gc, ac, wc, mr);
      chk("t1_rdata", rd, 32'hDEADBEEF);
      chk("t1_err", 32'(er), 32'd0);
      chk("t1_lat", 32'({gc[3:0], ac[3:0]}), 32'h02);
      chk("t1_memread", 32'(mr), 32'd3);

      reset_mid(2);
      st[0] = mk(1'b0, 2'd3, 32'd1, 32'h0);
      st[1] = mk(1'b0, 2'd3, 32'd2, 32'h0);
      seq = '0;
      for (int n = 0; n < 9; n++) begin
         run_cycle();
         if (n % 3 == 0) seq = {seq[3:0], a_gnt, b_gnt};
      end
      st[0].req = 1'b0; st[1].req = 1'b0;
      repeat (3) run_cycle();
      chk("t2_order", 32'(seq), FIXED ? 32'b101010 : 32'b100110);

      xact(1, 1'b1, 2'd3, 32'd7, 32'h12345678, rd, er, gc, ac, wc, mr);
      chk("t3_wcount", 32'(wc), 32'd1);
      xact(0, 1'b0, 2'd2, 32'd7, 32'h0, rd, er, gc, ac, wc, mr);
      chk("t3_rdata", rd, 32'h00005678);

      xact(0, 1'b0, 2'd3, 32'd64, 32'h0, rd, er, gc, ac, wc, mr);
      chk("t4_err", 32'(er), 32'd1);
      chk("t4_rdata", rd, 32'h0);
      chk("t4_mem", 32'({wc[3:0], mr}), 32'h0);

      xact(0, 1'b0, 2'd1, 32'd5, 32'h0, rd, er, gc, ac, wc, mr);
      chk("t5_byte", rd, 32'h000000EF);
      xact(0, 1'b0, 2'd0, 32'd5, 32'h0, rd, er, gc, ac, wc, mr);
      chk("t5_size0_err", 32'(er), 32'd1);

      st[1] = mk(1'b1, 2'd3, 32'd9, 32'hAAAA5555);
      run_cycle();
      chk("t6_gnt", 32'(b_gnt), 32'd1);
      run_cycle();
      chk("t6_memwrite", 32'(mem_MemWrite), 32'd1);
      reset_mid(2);
      xact(0, 1'b0, 2'd3, 32'd9, 32'h0, rd, er, gc, ac, wc, mr);
      chk("t6_untouched", rd, 32'h0BADF00D);
      chk("t6_regrant", 32'(gc), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         run_cycle();
         if (i == 1500) reset_mid(1);
         for (int p = 0; p < 2; p++) begin
            if (!st[p].req) begin
               if ($urandom_range(0, 2) == 0) st[p] = rand_cmd();
            end else if (eg[p]) begin
               if ($urandom_range(0, 1) == 1) begin
                  st[p].addr = $urandom; st[p].wdata = $urandom;
                  st[p].we = ~st[p].we; st[p].size = 2'($urandom_range(0, 3));
               end
            end else if (ea[p]) begin
               if ($urandom_range(0, 3) == 0) st[p] = rand_cmd();
               else st[p].req = 1'b0;
            end
         end
      end
      st[0].req = 1'b0; st[1].req = 1'b0;
      repeat (4) run_cycle();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
